// File: rtl/overlay_pkg.sv
// Shared overlay definitions: transparent colour key, wipe FSM states,
// visible line count and the stage-1 pixel bundle.
package overlay_pkg;

  localparam logic [5:0] COLOR_TRANSPARENT = 6'b100001;
  localparam int         V_VISIBLE         = 480;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    SHOWN  = 2'd2,
    HIDE   = 2'd3
  } reveal_state_e;

  typedef struct packed {
    logic       active;
    logic       hsync;
    logic       vsync;
    logic [9:0] y;
    logic [5:0] bg_rgb;
    logic [5:0] ov_rgb;
  } pixel_s;

  // Blanked pixel with syncs deasserted (active-low).
  localparam pixel_s PIXEL_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                    y: '0, bg_rgb: '0, ov_rgb: '0};

endpackage

// File: rtl/reveal_fsm.sv
// Frame-edge detector and wipe FSM that moves the reveal boundary row by
// REVEAL_STEP once per frame, saturating at 0 and V_VISIBLE.
module reveal_fsm
  import overlay_pkg::*;
#(
  parameter int REVEAL_STEP = 4,
  parameter int V_VISIBLE   = overlay_pkg::V_VISIBLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync_s1,
  input  logic       ov_enable,
  output logic [9:0] reveal_line
);

  localparam logic [10:0] STEP = 11'(REVEAL_STEP);
  localparam logic [10:0] VMAX = 11'(V_VISIBLE);

  reveal_state_e state, state_nxt;
  logic [9:0]    line_nxt;
  logic          vsync_prev;
  logic          frame_edge;
  logic [10:0]   up_sum, dn_diff;
  logic          inc_full, dec_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_prev  <= 1'b1;
      state       <= IDLE;
      reveal_line <= '0;
    end else begin
      vsync_prev  <= vsync_s1;
      state       <= state_nxt;
      reveal_line <= line_nxt;
    end
  end

  assign frame_edge = vsync_prev & ~vsync_s1;

  // 11-bit arithmetic so neither direction can wrap before clamping.
  assign up_sum    = {1'b0, reveal_line} + STEP;
  assign dn_diff   = {1'b0, reveal_line} - STEP;
  assign inc_full  = up_sum >= VMAX;
  assign dec_empty = {1'b0, reveal_line} <= STEP;

  // NOTE: defaults first keep every output driven on all paths (no latches).
  always_comb begin
    state_nxt = state;
    line_nxt  = reveal_line;
    if (frame_edge) begin
      if (ov_enable && state != SHOWN) begin
        state_nxt = inc_full ? SHOWN : REVEAL;
        line_nxt  = inc_full ? VMAX[9:0] : up_sum[9:0];
      end else if (!ov_enable && state != IDLE) begin
        state_nxt = dec_empty ? IDLE : HIDE;
        line_nxt  = dec_empty ? 10'd0 : dn_diff[9:0];
      end
    end
  end

endmodule

// File: rtl/overlay_mixer.sv
// Two-stage pixel pipeline compositing an emblem overlay above a wipe
// boundary onto the background, with syncs delayed to match.
module overlay_mixer
#(
  parameter int REVEAL_STEP = 4,
  parameter int V_VISIBLE   = overlay_pkg::V_VISIBLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       active,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [5:0] bg_rgb,
  input  logic [5:0] ov_rgb,
  input  logic       ov_enable,
  output logic [5:0] rgb_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [9:0] reveal_line
);

  import overlay_pkg::*;

  pixel_s s1;
  logic   show_ov;
  logic   unused_x;

  // The wipe is purely row-based; the column is accepted for interface symmetry.
  assign unused_x = ^x;

  // NOTE: asynchronous reset forces the pipeline inactive without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= PIXEL_IDLE;
    end else begin
      s1 <= '{active: active, hsync: hsync, vsync: vsync,
              y: y, bg_rgb: bg_rgb, ov_rgb: ov_rgb};
    end
  end

  reveal_fsm #(
    .REVEAL_STEP (REVEAL_STEP),
    .V_VISIBLE   (V_VISIBLE)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .vsync_s1    (s1.vsync),
    .ov_enable   (ov_enable),
    .reveal_line (reveal_line)
  );

  assign show_ov = s1.active && (s1.ov_rgb != COLOR_TRANSPARENT) && (s1.y < reveal_line);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out   <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      hsync_out <= s1.hsync;
      vsync_out <= s1.vsync;
      if (!s1.active)   rgb_out <= '0;
      else if (show_ov) rgb_out <= s1.ov_rgb;
      else              rgb_out <= s1.bg_rgb;
    end
  end

endmodule

// File: tb/tb_overlay_mixer.sv
// Directed self-checking bench for overlay_mixer: pipeline latency, compositing,
// wipe FSM sequencing and asynchronous reset.
module tb_overlay_mixer;
  import overlay_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       active, hsync, vsync;
  logic [5:0] bg_rgb, ov_rgb;
  logic       ov_enable;
  logic [5:0] rgb_out;
  logic       hsync_out, vsync_out;
  logic [9:0] reveal_line;

  int n_cmp = 0;
  int n_err = 0;

  overlay_mixer dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .active      (active),
    .hsync       (hsync),
    .vsync       (vsync),
    .bg_rgb      (bg_rgb),
    .ov_rgb      (ov_rgb),
    .ov_enable   (ov_enable),
    .rgb_out     (rgb_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .reveal_line (reveal_line)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One vsync pulse: a single 1->0 fall seen by the pipeline.
  task automatic frame();
    vsync = 1'b0;
    repeat (3) tick();
    vsync = 1'b1;
    repeat (3) tick();
  endtask

  task automatic set_pixel(input logic a, input logic [9:0] yy,
                           input logic [5:0] bg, input logic [5:0] ov);
    active = a; y = yy; bg_rgb = bg; ov_rgb = ov;
  endtask

  logic [7:0] hs_pat, vs_pat;

  initial begin
    reset = 1'b1; x = '0; y = '0; active = 1'b0; hsync = 1'b1; vsync = 1'b1;
    bg_rgb = '0; ov_rgb = '0; ov_enable = 1'b0;
    #1;
    check("rst_rgb", 16'(rgb_out), 16'h0);
    check("rst_hs", 16'(hsync_out), 16'h1);
    check("rst_vs", 16'(vsync_out), 16'h1);
    check("rst_line", 16'(reveal_line), 16'h0);
    repeat (2) tick();
    #2 reset = 1'b0;
    tick();

    // Blanking forces black regardless of colours.
    set_pixel(1'b0, 10'd5, 6'b111111, 6'b010101);
    repeat (2) tick();
    check("blank_rgb", 16'(rgb_out), 16'h0);

    // Sync patterns appear exactly two cycles later.
    hs_pat = 8'b1011_0010;
    vs_pat = 8'b1100_1101;
    for (int k = 0; k < 8; k++) begin
      hsync = hs_pat[k]; vsync = vs_pat[k];
      tick();
      if (k >= 1) begin
        check("hs_delay", 16'(hsync_out), 16'(hs_pat[k-1]));
        check("vs_delay", 16'(vsync_out), 16'(vs_pat[k-1]));
      end
    end
    hsync = 1'b1; vsync = 1'b1;
    repeat (3) tick();
    check("idle_line", 16'(reveal_line), 16'h0);

    // Reveal from IDLE; y=10 pixel only covered once line reaches 12.
    set_pixel(1'b1, 10'd10, 6'b000011, 6'b100100);
    ov_enable = 1'b1;
    frame();
    check("rev_4", 16'(reveal_line), 16'd4);
    check("px_at4", 16'(rgb_out), 16'h03);
    frame();
    check("rev_8", 16'(reveal_line), 16'd8);
    check("px_at8", 16'(rgb_out), 16'h03);
    frame();
    check("rev_12", 16'(reveal_line), 16'd12);
    check("px_at12", 16'(rgb_out), 16'h24);

    // ov_enable toggles between frame edges are ignored.
    ov_enable = 1'b0; repeat (4) tick(); ov_enable = 1'b1; tick();
    check("no_edge_hold", 16'(reveal_line), 16'd12);

    repeat (116) frame();
    check("rev_476", 16'(reveal_line), 16'd476);
    check("st_reveal", 16'(dut.u_fsm.state), 16'(REVEAL));
    frame();
    check("rev_480", 16'(reveal_line), 16'd480);
    check("st_shown", 16'(dut.u_fsm.state), 16'(SHOWN));
    repeat (2) frame();
    check("hold_480", 16'(reveal_line), 16'd480);

    // Transparent key falls through to background; opaque covers row 479 only.
    set_pixel(1'b1, 10'd479, 6'b000011, 6'b100001);
    repeat (2) tick();
    check("transp_bg", 16'(rgb_out), 16'h03);
    set_pixel(1'b1, 10'd479, 6'b000011, 6'b110000);
    repeat (2) tick();
    check("opaque_479", 16'(rgb_out), 16'h30);
    set_pixel(1'b1, 10'd480, 6'b000011, 6'b110000);
    repeat (2) tick();
    check("bg_480", 16'(rgb_out), 16'h03);

    // Hide, reverse, hide fully.
    ov_enable = 1'b0;
    frame();
    check("hide_476", 16'(reveal_line), 16'd476);
    check("st_hide", 16'(dut.u_fsm.state), 16'(HIDE));
    frame();
    check("hide_472", 16'(reveal_line), 16'd472);
    ov_enable = 1'b1;
    frame();
    check("rerev_476", 16'(reveal_line), 16'd476);
    check("st_rerev", 16'(dut.u_fsm.state), 16'(REVEAL));
    ov_enable = 1'b0;
    repeat (118) frame();
    check("hide_4", 16'(reveal_line), 16'd4);
    frame();
    check("hide_0", 16'(reveal_line), 16'd0);
    check("st_idle", 16'(dut.u_fsm.state), 16'(IDLE));
    frame();
    check("hold_0", 16'(reveal_line), 16'd0);

    // Asynchronous reset in the middle of a reveal.
    ov_enable = 1'b1;
    repeat (50) frame();
    check("rev_200", 16'(reveal_line), 16'd200);
    set_pixel(1'b1, 10'd300, 6'b111111, 6'b100001);
    hsync = 1'b0;
    repeat (2) tick();
    check("pre_rst_rgb", 16'(rgb_out), 16'h3f);
    check("pre_rst_hs", 16'(hsync_out), 16'h0);
    #2 reset = 1'b1;
    #1;
    check("arst_rgb", 16'(rgb_out), 16'h0);
    check("arst_hs", 16'(hsync_out), 16'h1);
    check("arst_vs", 16'(vsync_out), 16'h1);
    check("arst_line", 16'(reveal_line), 16'h0);
    check("arst_state", 16'(dut.u_fsm.state), 16'(IDLE));
    hsync = 1'b1;
    repeat (2) tick();
    #2 reset = 1'b0;
    repeat (5) tick();
    check("post_rst_line", 16'(reveal_line), 16'h0);
    frame();
    check("post_rst_edge", 16'(reveal_line), 16'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
